// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared opcode, FSM state and bubble constants for the MIPS core
package mips_defs;

    // Memory opcodes (Instr[31:26])
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    // MEM stage bus FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Bubble instruction word
    localparam logic [31:0] INSTR_NOP = 32'h0;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - opcode decode, byte-lane alignment and load extension
module load_store_align
    import mips_defs::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic        o_is_load,
    output logic        o_is_store,
    output logic        o_misaligned,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ext_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lane pick from the read word
    always_comb begin
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    // Decode; ext_rdata stays 0 for anything that is not a load so X read data never leaks
    always_comb begin
        o_is_load    = 1'b0;
        o_is_store   = 1'b0;
        o_misaligned = 1'b0;
        o_be         = 4'b0000;
        o_wdata      = 32'h0;
        o_ext_rdata  = 32'h0;
        case (i_opcode)
            OP_LW: begin
                o_is_load    = 1'b1;
                o_misaligned = (i_addr != 2'b00);
                o_be         = 4'b1111;
                o_ext_rdata  = i_rdata;
            end
            OP_LH: begin
                o_is_load    = 1'b1;
                o_misaligned = i_addr[0];
                o_be         = 4'b1111;
                o_ext_rdata  = {{16{w_half[15]}}, w_half};
            end
            OP_LHU: begin
                o_is_load    = 1'b1;
                o_misaligned = i_addr[0];
                o_be         = 4'b1111;
                o_ext_rdata  = {16'h0, w_half};
            end
            OP_LB: begin
                o_is_load    = 1'b1;
                o_be         = 4'b1111;
                o_ext_rdata  = {{24{w_byte[7]}}, w_byte};
            end
            OP_LBU: begin
                o_is_load    = 1'b1;
                o_be         = 4'b1111;
                o_ext_rdata  = {24'h0, w_byte};
            end
            OP_SW: begin
                o_is_store   = 1'b1;
                o_misaligned = (i_addr != 2'b00);
                o_be         = 4'b1111;
                o_wdata      = i_wdata;
            end
            OP_SH: begin
                o_is_store   = 1'b1;
                o_misaligned = i_addr[0];
                o_be         = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
            end
            OP_SB: begin
                o_is_store   = 1'b1;
                o_be         = 4'b0001 << i_addr;
                o_wdata      = {4{i_wdata[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory handshake, MEM/WB register, stall counter
module mem_stage
    import mips_defs::*;
#(
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       PC3,
    input  logic [31:0]       Instr3,
    input  logic [31:0]       Result3,
    input  logic [31:0]       WriteData3,
    output logic [31:0]       PC4,
    output logic [31:0]       Instr4,
    output logic [31:0]       Result4,
    output logic [31:0]       RD4,
    output logic              mem_exc4,
    output logic              stall_mem,
    output logic              dm_req,
    output logic              dm_we,
    output logic [31:0]       dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ack,
    output logic [SCNT_W-1:0] stall_cycles
);

    logic [0:0]        r_state;
    logic [31:0]       r_hold_addr;
    logic [3:0]        r_hold_be;
    logic [31:0]       r_hold_wdata;
    logic              r_hold_we;
    logic [5:0]        r_hold_op;
    logic [1:0]        r_hold_lo;
    logic [31:0]       r_pc4;
    logic [31:0]       r_instr4;
    logic [31:0]       r_result4;
    logic [31:0]       r_rd4;
    logic              r_exc4;
    logic [SCNT_W-1:0] r_cnt;

    logic              w_busy;
    logic [5:0]        w_align_op;
    logic [1:0]        w_align_lo;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_mis;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ext;
    logic              w_mem_op;
    logic              w_exc;
    logic              w_req;
    logic              w_we;
    logic [31:0]       w_addr;
    logic [3:0]        w_bus_be;
    logic [31:0]       w_bus_wdata;
    logic              w_stall;
    logic              w_done;

    assign w_busy = (r_state == ST_BUSY);

    // While waiting, decode the held access so load extension is independent of upstream
    assign w_align_op = w_busy ? r_hold_op : Instr3[31:26];
    assign w_align_lo = w_busy ? r_hold_lo : Result3[1:0];

    load_store_align u_align (
        .i_opcode     (w_align_op),
        .i_addr       (w_align_lo),
        .i_wdata      (WriteData3),
        .i_rdata      (dm_rdata),
        .o_is_load    (w_is_load),
        .o_is_store   (w_is_store),
        .o_misaligned (w_mis),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_ext_rdata  (w_ext)
    );

    assign w_mem_op = (w_is_load | w_is_store) & ~w_mis;
    assign w_exc    = ~w_busy & (w_is_load | w_is_store) & w_mis;

    // Bus drive: live decode in IDLE, hold registers in BUSY; reset forces the bus idle at once
    always_comb begin
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_addr      = 32'h0;
        w_bus_be    = 4'b0000;
        w_bus_wdata = 32'h0;
        w_stall     = 1'b0;
        w_done      = 1'b0;
        if (!reset) begin
            if (w_busy) begin
                w_req       = 1'b1;
                w_we        = r_hold_we;
                w_addr      = r_hold_addr;
                w_bus_be    = r_hold_be;
                w_bus_wdata = r_hold_wdata;
                w_stall     = ~dm_ack;
                w_done      = dm_ack;
            end else if (w_mem_op) begin
                w_req       = 1'b1;
                w_we        = w_is_store;
                w_addr      = {Result3[31:2], 2'b00};
                w_bus_be    = w_be;
                w_bus_wdata = w_wdata;
                w_stall     = ~dm_ack;
                w_done      = dm_ack;
            end
        end
    end

    assign dm_req       = w_req;
    assign dm_we        = w_we;
    assign dm_addr      = w_addr;
    assign dm_be        = w_bus_be;
    assign dm_wdata     = w_bus_wdata;
    assign stall_mem    = w_stall;
    assign PC4          = r_pc4;
    assign Instr4       = r_instr4;
    assign Result4      = r_result4;
    assign RD4          = r_rd4;
    assign mem_exc4     = r_exc4;
    assign stall_cycles = r_cnt;

    // FSM and hold registers: capture the access the first cycle it is not acknowledged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_hold_addr  <= 32'h0;
            r_hold_be    <= 4'b0000;
            r_hold_wdata <= 32'h0;
            r_hold_we    <= 1'b0;
            r_hold_op    <= 6'h0;
            r_hold_lo    <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_op && !dm_ack) begin
                        r_state      <= ST_BUSY;
                        r_hold_addr  <= w_addr;
                        r_hold_be    <= w_bus_be;
                        r_hold_wdata <= w_bus_wdata;
                        r_hold_we    <= w_we;
                        r_hold_op    <= Instr3[31:26];
                        r_hold_lo    <= Result3[1:0];
                    end
                end
                default: begin
                    if (dm_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, exception bubble on misalignment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc4     <= 32'h0;
            r_instr4  <= INSTR_NOP;
            r_result4 <= 32'h0;
            r_rd4     <= 32'h0;
            r_exc4    <= 1'b0;
        end else if (w_stall) begin
            r_pc4     <= 32'h0;
            r_instr4  <= INSTR_NOP;
            r_result4 <= 32'h0;
            r_rd4     <= 32'h0;
            r_exc4    <= 1'b0;
        end else if (w_exc) begin
            r_pc4     <= PC3;
            r_instr4  <= INSTR_NOP;
            r_result4 <= 32'h0;
            r_rd4     <= 32'h0;
            r_exc4    <= 1'b1;
        end else begin
            r_pc4     <= PC3;
            r_instr4  <= Instr3;
            r_result4 <= Result3;
            r_rd4     <= (w_done && w_is_load) ? w_ext : 32'h0;
            r_exc4    <= 1'b0;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != {SCNT_W{1'b1}})) begin
            r_cnt <= r_cnt + SCNT_W'(1);
        end
    end

endmodule
